noc_router: RTL and testbench

// - One 5-port (North/South/East/West/Local) mesh NoC router tile at fixed coordinates (XCOORD,YCOORD).
// - Buffers single-flit packets per input and routes them dimension-ordered (X first, then Y).
// - Arbitrates round-robin per output; valid/ready handshake on all ten channels.
// - Instantiated once per mesh node; Local port connects the node's endpoint.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/router_input_fifo.sv | 43 ++++
 rtl/noc_router.sv | 123 ++++++++++++
 tb/tb_noc_router.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Flit field layout and the dimension-ordered (X then Y) route decision shared by the mesh router.
package noc_pkg;
  localparam int DATA_W = 32;
  localparam int DX_HI  = 31;
  localparam int DX_LO  = 28;
  localparam int DY_HI  = 27;
  localparam int DY_LO  = 24;
  localparam int NPORTS = 5;

  typedef enum logic [2:0] {N = 3'd0, S = 3'd1, E = 3'd2, W = 3'd3, L = 3'd4} dir_e;

  function automatic dir_e route(input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [3:0] xc, input logic [3:0] yc);
    if (dx > xc)      return E;
    else if (dx < xc) return W;
    else if (dy > yc) return N;
    else if (dy < yc) return S;
    else              return L;
  endfunction
endpackage

// File: rtl/router_input_fifo.sv
// Per-input flit buffer; the head is visible combinationally so routing can look at it every cycle.
module router_input_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/noc_router.sv
// Five-port mesh router tile: per-input FIFOs, XY routing, round-robin arbiter and register per output.
module noc_router #(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = noc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] n_in_data,
  input  logic              n_in_valid,
  output logic              n_in_ready,
  output logic [DATA_W-1:0] n_out_data,
  output logic              n_out_valid,
  input  logic              n_out_ready,
  input  logic [DATA_W-1:0] s_in_data,
  input  logic              s_in_valid,
  output logic              s_in_ready,
  output logic [DATA_W-1:0] s_out_data,
  output logic              s_out_valid,
  input  logic              s_out_ready,
  input  logic [DATA_W-1:0] e_in_data,
  input  logic              e_in_valid,
  output logic              e_in_ready,
  output logic [DATA_W-1:0] e_out_data,
  output logic              e_out_valid,
  input  logic              e_out_ready,
  input  logic [DATA_W-1:0] w_in_data,
  input  logic              w_in_valid,
  output logic              w_in_ready,
  output logic [DATA_W-1:0] w_out_data,
  output logic              w_out_valid,
  input  logic              w_out_ready,
  input  logic [DATA_W-1:0] l_in_data,
  input  logic              l_in_valid,
  output logic              l_in_ready,
  output logic [DATA_W-1:0] l_out_data,
  output logic              l_out_valid,
  input  logic              l_out_ready
);
  import noc_pkg::*;

  localparam logic [3:0] XC = 4'(XCOORD);
  localparam logic [3:0] YC = 4'(YCOORD);

  logic [DATA_W-1:0] in_data    [NPORTS];
  logic [DATA_W-1:0] head       [NPORTS];
  dir_e              rt         [NPORTS];
  logic [DATA_W-1:0] out_data_q [NPORTS];
  logic [2:0]        rr_q       [NPORTS];
  logic [2:0]        gnt_idx    [NPORTS];
  logic [NPORTS-1:0] in_valid, in_ready, out_ready, push, pop, full, empty;
  logic [NPORTS-1:0] out_valid_q, load_ok, gnt_vld;

  assign in_data = '{n_in_data, s_in_data, e_in_data, w_in_data, l_in_data};
  assign in_valid  = {l_in_valid, w_in_valid, e_in_valid, s_in_valid, n_in_valid};
  assign out_ready = {l_out_ready, w_out_ready, e_out_ready, s_out_ready, n_out_ready};
  assign {l_in_ready, w_in_ready, e_in_ready, s_in_ready, n_in_ready} = in_ready;
  assign {l_out_valid, w_out_valid, e_out_valid, s_out_valid, n_out_valid} = out_valid_q;
  assign n_out_data = out_data_q[0];
  assign s_out_data = out_data_q[1];
  assign e_out_data = out_data_q[2];
  assign w_out_data = out_data_q[3];
  assign l_out_data = out_data_q[4];
  assign load_ok    = ~out_valid_q | out_ready;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
    // Ready ignores a same-cycle pop: a full FIFO never accepts.
    assign in_ready[gi] = rst_n && !full[gi];
    assign push[gi]     = in_valid[gi] && in_ready[gi];
    router_input_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[gi]),
      .pop_i   (pop[gi]),
      .wdata_i (in_data[gi]),
      .head_o  (head[gi]),
      .full_o  (full[gi]),
      .empty_o (empty[gi])
    );
    assign rt[gi] = route(head[gi][DX_HI:DX_LO], head[gi][DY_HI:DY_LO], XC, YC);
  end

  // Each head routes to exactly one output, so an input can never win two grants at once.
  always_comb begin
    logic [3:0] cand;
    gnt_vld = '0;
    pop     = '0;
    cand    = '0;
    for (int o = 0; o < NPORTS; o++) begin
      gnt_idx[o] = '0;
      for (int k = 0; k < NPORTS; k++) begin
        cand = {1'b0, rr_q[o]} + 4'(k);
        if (cand >= 4'(NPORTS)) cand = cand - 4'(NPORTS);
        if (!gnt_vld[o] && load_ok[o] && !empty[cand[2:0]] && rt[cand[2:0]] == dir_e'(3'(o))) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand[2:0];
        end
      end
      if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        out_data_q[o] <= '0;
        rr_q[o]       <= 3'd0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt_vld[o]) begin
          out_valid_q[o] <= 1'b1;
          out_data_q[o]  <= head[gnt_idx[o]];
          rr_q[o]        <= (gnt_idx[o] == 3'(NPORTS - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_router.sv
// Directed and randomized checks of the router at (2,2) against a scoreboard of accepted flits.
module tb_noc_router;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data   [5];
  logic        in_valid  [5];
  logic        in_ready  [5];
  logic [31:0] out_data  [5];
  logic        out_valid [5];
  logic        out_ready [5];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] data;
  } ent_t;
  ent_t sb[$];

  logic        stall   [5];
  logic [31:0] stall_d [5];
  logic        acc;
  logic        acc_v [5];
  int          nacc;
  logic [31:0] seen;

  always #5 clk = ~clk;

  noc_router #(.XCOORD(2), .YCOORD(2), .FIFO_DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .n_in_data(in_data[0]), .n_in_valid(in_valid[0]), .n_in_ready(in_ready[0]),
    .n_out_data(out_data[0]), .n_out_valid(out_valid[0]), .n_out_ready(out_ready[0]),
    .s_in_data(in_data[1]), .s_in_valid(in_valid[1]), .s_in_ready(in_ready[1]),
    .s_out_data(out_data[1]), .s_out_valid(out_valid[1]), .s_out_ready(out_ready[1]),
    .e_in_data(in_data[2]), .e_in_valid(in_valid[2]), .e_in_ready(in_ready[2]),
    .e_out_data(out_data[2]), .e_out_valid(out_valid[2]), .e_out_ready(out_ready[2]),
    .w_in_data(in_data[3]), .w_in_valid(in_valid[3]), .w_in_ready(in_ready[3]),
    .w_out_data(out_data[3]), .w_out_valid(out_valid[3]), .w_out_ready(out_ready[3]),
    .l_in_data(in_data[4]), .l_in_valid(in_valid[4]), .l_in_ready(in_ready[4]),
    .l_out_data(out_data[4]), .l_out_valid(out_valid[4]), .l_out_ready(out_ready[4])
  );

  // Output index for a flit at router (2,2): N=0 S=1 E=2 W=3 L=4.
  function automatic int ref_route(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[31:28]);
    dy = int'(f[27:24]);
    if (dx > 2) return 2;
    if (dx < 2) return 3;
    if (dy > 2) return 0;
    if (dy < 2) return 1;
    return 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [31:0] d);
    int n;
    logic a;
    n = 0;
    in_data[p]  = d;
    in_valid[p] = 1'b1;
    do begin
      a = in_ready[p];
      tick();
      n++;
    end while (!a && n < 50);
    in_valid[p] = 1'b0;
    check("send_accept", a, 1);
  endtask

  // A flit leaving on output o must be pending, route to o, and have no older pending flit
  // from the same input to the same output.
  task automatic sb_out(input int o, input logic [31:0] d);
    int f, early;
    f = -1;
    early = 0;
    for (int j = 0; j < sb.size(); j++)
      if (f < 0 && ref_route(sb[j].data) == o && sb[j].data == d) f = j;
    check($sformatf("out%0d_expected", o), (f >= 0), 1);
    if (f >= 0) begin
      for (int j = 0; j < f; j++)
        if (sb[j].src == sb[f].src && ref_route(sb[j].data) == o) early++;
      check($sformatf("out%0d_order", o), early, 0);
      sb.delete(f);
    end
  endtask

  // Inputs change at posedge+1, so at the falling edge valid&&ready predicts the next transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int o = 0; o < 5; o++) begin
        stall[o]   = 1'b0;
        stall_d[o] = '0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (stall[o]) check($sformatf("out%0d_hold", o), {out_valid[o], out_data[o]}, {1'b1, stall_d[o]});
        if (out_valid[o] && out_ready[o]) sb_out(o, out_data[o]);
        stall[o]   = out_valid[o] && !out_ready[o];
        stall_d[o] = out_data[o];
      end
      for (int i = 0; i < 5; i++)
        if (in_valid[i] && in_ready[i]) sb.push_back('{src: 3'(i), data: in_data[i]});
    end
  end

  initial begin
    for (int p = 0; p < 5; p++) begin
      in_data[p]   = '0;
      in_valid[p]  = 1'b0;
      out_ready[p] = 1'b1;
    end

    // Reset hold and release
    rst_n = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 5; p++) begin
      check($sformatf("rst_out_valid%0d", p), out_valid[p], 0);
      check($sformatf("rst_in_ready%0d", p), in_ready[p], 0);
    end
    rst_n = 1'b1;
    #1;
    for (int p = 0; p < 5; p++) check($sformatf("rel_in_ready%0d", p), in_ready[p], 1);

    // Local -> East, one cycle after acceptance
    send(4, 32'h3200_0ABC);
    tick();
    check("t2_e_valid", out_valid[2], 1);
    check("t2_e_data", out_data[2], 32'h3200_0ABC);
    for (int p = 0; p < 5; p++) if (p != 2) check($sformatf("t2_idle%0d", p), out_valid[p], 0);
    tick();
    check("t2_e_drop", out_valid[2], 0);
    check("t2_e_datahold", out_data[2], 32'h3200_0ABC);

    // Four simultaneous routes to four distinct outputs
    in_data[0] = 32'h2200_0001;
    in_data[3] = 32'h2300_0002;
    in_data[2] = 32'h2100_0003;
    in_data[1] = 32'h1500_0004;
    for (int p = 0; p < 4; p++) in_valid[p] = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) in_valid[p] = 1'b0;
    tick();
    check("t3_l_valid", out_valid[4], 1);
    check("t3_l_data", out_data[4], 32'h2200_0001);
    check("t3_n_data", {out_valid[0], out_data[0]}, {1'b1, 32'h2300_0002});
    check("t3_s_data", {out_valid[1], out_data[1]}, {1'b1, 32'h2100_0003});
    check("t3_w_data", {out_valid[3], out_data[3]}, {1'b1, 32'h1500_0004});

    // N and S contend for West: N first both times (pointer sits past S)
    for (int rep = 0; rep < 2; rep++) begin
      in_data[0] = 32'h1200_00AA;
      in_data[1] = 32'h1200_00BB;
      in_valid[0] = 1'b1;
      in_valid[1] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      tick();
      check($sformatf("t4_first_r%0d", rep), {out_valid[3], out_data[3]}, {1'b1, 32'h1200_00AA});
      tick();
      check($sformatf("t4_second_r%0d", rep), {out_valid[3], out_data[3]}, {1'b1, 32'h1200_00BB});
      tick();
    end
    // Pointer now past S, so L (index 4) beats N (index 0)
    in_data[0] = 32'h1200_00DD;
    in_data[4] = 32'h1200_00CC;
    in_valid[0] = 1'b1;
    in_valid[4] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    in_valid[4] = 1'b0;
    tick();
    check("t4_rr_first", {out_valid[3], out_data[3]}, {1'b1, 32'h1200_00CC});
    tick();
    check("t4_rr_second", {out_valid[3], out_data[3]}, {1'b1, 32'h1200_00DD});
    tick();

    // Backpressure: Local blocked, six flits from East
    out_ready[4] = 1'b0;
    in_data[2]  = 32'h2200_0000;
    in_valid[2] = 1'b1;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      acc = in_valid[2] && in_ready[2];
      tick();
      if (acc) begin
        nacc++;
        if (nacc < 6) in_data[2] = 32'h2200_0000 + 32'(nacc);
        else in_valid[2] = 1'b0;
      end
    end
    check("t5_accepted", nacc, 5);
    check("t5_in_ready_full", in_ready[2], 0);
    check("t5_l_held", {out_valid[4], out_data[4]}, {1'b1, 32'h2200_0000});
    out_ready[4] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t5_out%0d", i), {out_valid[4], out_data[4]}, {1'b1, 32'h2200_0000 + 32'(i)});
      acc = in_valid[2] && in_ready[2];
      tick();
      if (acc) in_valid[2] = 1'b0;
    end
    check("t5_last_accepted", in_valid[2], 0);
    tick();

    // Reset while buffers are occupied
    out_ready[4] = 1'b0;
    out_ready[2] = 1'b0;
    in_data[0] = 32'h2200_0100;
    in_data[1] = 32'h2200_0101;
    in_data[3] = 32'h3200_0102;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    in_valid[3] = 1'b1;
    repeat (4) tick();
    for (int p = 0; p < 5; p++) begin
      in_valid[p]  = 1'b0;
      out_ready[p] = 1'b1;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 5; p++) check($sformatf("t6_quiet%0d_c%0d", p, c), out_valid[p], 0);
      tick();
    end
    send(0, 32'h0200_0777);
    tick();
    check("t6_after_reset", {out_valid[3], out_data[3]}, {1'b1, 32'h0200_0777});
    tick();

    // Randomized traffic with random backpressure
    for (int p = 0; p < 5; p++) acc_v[p] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 5; p++) acc_v[p] = in_valid[p] && in_ready[p];
      tick();
      for (int p = 0; p < 5; p++) begin
        if (acc_v[p] || !in_valid[p]) begin
          in_valid[p] = ($urandom_range(0, 99) < 60);
          in_data[p]  = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 24'($urandom)};
        end
        out_ready[p] = ($urandom_range(0, 99) < 70);
      end
    end

    // Drain: finish pending sends, then everything must come out
    for (int p = 0; p < 5; p++) out_ready[p] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 5; p++) acc_v[p] = in_valid[p] && in_ready[p];
      tick();
      for (int p = 0; p < 5; p++) if (acc_v[p]) in_valid[p] = 1'b0;
    end
    seen = 32'(sb.size());
    check("drain_sb_empty", seen, 0);
    for (int p = 0; p < 5; p++) check($sformatf("drain_idle%0d", p), out_valid[p], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
